// File: rtl/despertador_entradas_pkg.sv
// Shared constants for the alarm-clock input PIO: register map, input bit
// positions and the debounce state encoding.
package despertador_entradas_pkg;

    localparam int NUM_ENTRADAS = 5;

    // Bit positions of each input inside DATA, RAW and EDGE_CAPTURE
    localparam int BIT_HORA    = 0;
    localparam int BIT_MIN     = 1;
    localparam int BIT_APAGAR  = 2;
    localparam int BIT_INICIO  = 3;
    localparam int BIT_MODO    = 4;

    // Buttons only report presses; switches report both directions
    localparam logic [NUM_ENTRADAS-1:0] PRESS_ONLY_MASK = 5'b00111;

    // Avalon-MM register indices
    localparam logic [1:0] ADDR_DATA         = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;
    localparam logic [1:0] ADDR_RAW          = 2'd3;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } debounce_state_e;

    // Places a per-input vector in the low bits of a 32-bit bus word
    function automatic logic [31:0] zeroExtend(input logic [NUM_ENTRADAS-1:0] v);
        return {{(32-NUM_ENTRADAS){1'b0}}, v};
    endfunction

endpackage

// File: rtl/entrada_antirrebote.sv
// One input channel: 2-FF synchronizer, debounce FSM and press/release
// pulses. The input is already active-high (buttons inverted by the caller).
// An input found active right after reset is adopted silently, without
// producing an edge pulse. DEBOUNCE_CYCLES must be at least 2.
module entrada_antirrebote
    import despertador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic raw_o,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The level is accepted on the cycle the counter would reach DEBOUNCE_CYCLES-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_q;
    debounce_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic [1:0]       warm_q, warm_d;
    logic             primed_q, primed_d;
    logic             update;

    // Two-stage synchronizer for the asynchronous input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], level_i};
        end
    end

    // Debounce next-state: count while the input disagrees, accept at the limit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        update  = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (sync_q[1] != level_q) begin
                    state_d = DB_COUNTING;
                end
            end
            DB_COUNTING: begin
                if (sync_q[1] == level_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                    level_d = sync_q[1];
                    update  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Edge reporting is armed once the synchronizer holds a post-reset sample
    always_comb begin
        warm_d   = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        primed_d = primed_q | update |
                   ((warm_q == 2'd2) && (state_q == DB_STABLE) && (sync_q[1] == level_q));
    end

    // Debounce state, counter, accepted level and arming flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DB_STABLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            warm_q   <= 2'd0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            warm_q   <= warm_d;
            primed_q <= primed_d;
        end
    end

    assign raw_o   = sync_q[1];
    assign level_o = level_q;
    assign rise_o  = update & level_d & primed_q;
    assign fall_o  = update & ~level_d & primed_q;

endmodule

// File: rtl/despertador_entradas_pio.sv
// Avalon-MM input PIO for the alarm clock: three buttons and two switches,
// debounced, with edge capture, interrupt mask and a level interrupt.
// Optional feature: define ENTRADAS_AUTOREPEAT_EN to re-trigger the hour and
// minute buttons while they are held.
module despertador_entradas_pio
    import despertador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        btnhora,
    input  logic        btnmin,
    input  logic        btnapagar,
    input  logic        swinicio,
    input  logic        swmodo,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    logic [NUM_ENTRADAS-1:0] entradasIn;
    logic [NUM_ENTRADAS-1:0] raw;
    logic [NUM_ENTRADAS-1:0] level;
    logic [NUM_ENTRADAS-1:0] rise;
    logic [NUM_ENTRADAS-1:0] fall;
    logic [NUM_ENTRADAS-1:0] repeatSet;
    logic [NUM_ENTRADAS-1:0] edgeSet;
    logic [NUM_ENTRADAS-1:0] clearBits;
    logic [NUM_ENTRADAS-1:0] irqMask_q, irqMask_d;
    logic [NUM_ENTRADAS-1:0] capture_q, capture_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    irq_q, irq_d;
    logic                    wrEn;
    logic                    rdEn;
    logic                    unused_ok;

    // Map pins onto the input vector; buttons become 1 when pressed
    always_comb begin
        entradasIn             = '0;
        entradasIn[BIT_HORA]   = ~btnhora;
        entradasIn[BIT_MIN]    = ~btnmin;
        entradasIn[BIT_APAGAR] = ~btnapagar;
        entradasIn[BIT_INICIO] = swinicio;
        entradasIn[BIT_MODO]   = swmodo;
    end

    for (genvar i = 0; i < NUM_ENTRADAS; i++) begin : g_entrada
        entrada_antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk    (clk),
            .reset  (reset),
            .level_i(entradasIn[i]),
            .raw_o  (raw[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

`ifdef ENTRADAS_AUTOREPEAT_EN
    localparam int REPEAT_BITS = 2;
    localparam int REP_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W       = $clog2(REP_MAX + 1);

    logic [REP_W-1:0]       repCnt_q [REPEAT_BITS];
    logic [REP_W-1:0]       repCnt_d [REPEAT_BITS];
    logic [REPEAT_BITS-1:0] repFirst_q, repFirst_d;
    logic [REPEAT_BITS-1:0] repFire;

    // Hold timers for hour/minute: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD
    always_comb begin
        repFirst_d = repFirst_q;
        repFire    = '0;
        for (int i = 0; i < REPEAT_BITS; i++) begin
            repCnt_d[i] = repCnt_q[i];
            if (!level[i]) begin
                repCnt_d[i]   = '0;
                repFirst_d[i] = 1'b0;
            end else if ((!repFirst_q[i] && repCnt_q[i] == REP_W'(REPEAT_DELAY - 1)) ||
                         ( repFirst_q[i] && repCnt_q[i] == REP_W'(REPEAT_PERIOD - 1))) begin
                repFire[i]    = 1'b1;
                repCnt_d[i]   = '0;
                repFirst_d[i] = 1'b1;
            end else begin
                repCnt_d[i] = repCnt_q[i] + 1'b1;
            end
        end
    end

    // Auto-repeat timer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REPEAT_BITS; i++) begin
                repCnt_q[i] <= '0;
            end
            repFirst_q <= '0;
        end else begin
            for (int i = 0; i < REPEAT_BITS; i++) begin
                repCnt_q[i] <= repCnt_d[i];
            end
            repFirst_q <= repFirst_d;
        end
    end

    assign repeatSet = {{(NUM_ENTRADAS-REPEAT_BITS){1'b0}}, repFire};
    assign unused_ok = &{1'b0, writedata[31:NUM_ENTRADAS]};
`else
    assign repeatSet = '0;
    assign unused_ok = &{1'b0, writedata[31:NUM_ENTRADAS], REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    assign wrEn = chipselect & write;
    assign rdEn = chipselect & read;

    // Register file next-state: new edges win over a simultaneous write-1-clear
    always_comb begin
        edgeSet   = (rise & PRESS_ONLY_MASK) | ((rise | fall) & ~PRESS_ONLY_MASK) | repeatSet;
        clearBits = (wrEn && address == ADDR_EDGE_CAPTURE) ? writedata[NUM_ENTRADAS-1:0] : '0;
        capture_d = (capture_q & ~clearBits) | edgeSet;
        irqMask_d = (wrEn && address == ADDR_IRQ_MASK) ? writedata[NUM_ENTRADAS-1:0] : irqMask_q;
        irq_d     = |(capture_q & irqMask_q);
        readdata_d = readdata_q;
        if (rdEn) begin
            case (address)
                ADDR_DATA:         readdata_d = zeroExtend(level);
                ADDR_IRQ_MASK:     readdata_d = zeroExtend(irqMask_q);
                ADDR_EDGE_CAPTURE: readdata_d = zeroExtend(capture_q);
                ADDR_RAW:          readdata_d = zeroExtend(raw);
                default:           readdata_d = '0;
            endcase
        end
    end

    // Bus-visible registers and the interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irqMask_q  <= '0;
            capture_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqMask_q  <= irqMask_d;
            capture_q  <= capture_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_despertador_entradas_pio.sv
// Bench for despertador_entradas_pio with short debounce/repeat timings.
// Register-map vectors come from a table; debounce, edge priority, reset and
// auto-repeat behaviour are exercised with hand-written cycle sequences.
module tb_despertador_entradas_pio;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        btnhora, btnmin, btnapagar, swinicio, swmodo;
    logic        chipselect, read, write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int numCompared   = 0;
    int numMismatched = 0;

    typedef struct {
        logic        doWrite;
        logic        wrSelect;
        logic [1:0]  wrAddr;
        logic [31:0] wrData;
        logic [1:0]  rdAddr;
        logic [31:0] expRead;
        logic        expIrq;
    } regVector_t;

    regVector_t regVectors [12];

    always #5 clk = ~clk;

    despertador_entradas_pio #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btnhora   (btnhora),
        .btnmin    (btnmin),
        .btnapagar (btnapagar),
        .swinicio  (swinicio),
        .swmodo    (swmodo),
        .chipselect(chipselect),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    // Compares one observed value with its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One-cycle Avalon write, called on a falling edge
    task automatic writeReg(input logic sel, input logic [1:0] addr, input logic [31:0] data);
        chipselect = sel;
        write      = 1'b1;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
    endtask

    // One-cycle Avalon read, data sampled after the latency-1 edge
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = addr;
        @(negedge clk);
        data       = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    // Applies one table vector: optional write, then read-back and irq check
    task automatic applyStimulus(input regVector_t v, input int idx);
        logic [31:0] rd;
        if (v.doWrite) writeReg(v.wrSelect, v.wrAddr, v.wrData);
        readReg(v.rdAddr, rd);
        checkOutput($sformatf("regvec%0d_read", idx), rd, v.expRead);
        checkOutput($sformatf("regvec%0d_irq", idx), {31'd0, irq}, {31'd0, v.expIrq});
    endtask

    initial begin
        logic [31:0] rd;
        int          irqRises [$];
        logic        prevIrq;

        regVectors[0]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000, 1'b0};
        regVectors[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b0};
        regVectors[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0};
        regVectors[3]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_0000, 1'b0};
        regVectors[4]  = '{1'b1, 1'b1, 2'd1, 32'h0000_001F, 2'd1, 32'h0000_001F, 1'b0};
        regVectors[5]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFE0, 2'd1, 32'h0000_0000, 1'b0};
        regVectors[6]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0015, 2'd1, 32'h0000_0000, 1'b0};
        regVectors[7]  = '{1'b1, 1'b1, 2'd0, 32'h0000_001F, 2'd0, 32'h0000_0000, 1'b0};
        regVectors[8]  = '{1'b1, 1'b1, 2'd3, 32'h0000_001F, 2'd3, 32'h0000_0000, 1'b0};
        regVectors[9]  = '{1'b1, 1'b1, 2'd2, 32'h0000_001F, 2'd2, 32'h0000_0000, 1'b0};
        regVectors[10] = '{1'b1, 1'b1, 2'd1, 32'h0000_000A, 2'd1, 32'h0000_000A, 1'b0};
        regVectors[11] = '{1'b1, 1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b0};

        reset      = 1'b0;
        btnhora    = 1'b1;
        btnmin     = 1'b1;
        btnapagar  = 1'b1;
        swinicio   = 1'b0;
        swmodo     = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset_readdata", readdata, 32'd0);
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] register map vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(regVectors[i], i);
        end

        // btnhora held 10 cycles: level at edge DEB+2, visible on readdata and irq one cycle later
        $display("[TB] btnhora press");
        writeReg(1'b1, 2'd1, 32'h01);
        btnhora    = 1'b0;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hora_data_c%0d", k), readdata, (k >= DEB + 3) ? 32'h01 : 32'h00);
            checkOutput($sformatf("hora_irq_c%0d", k), {31'd0, irq}, (k >= DEB + 3) ? 32'd1 : 32'd0);
        end
        chipselect = 1'b0;
        read       = 1'b0;
        btnhora    = 1'b1;
        readReg(2'd2, rd);
        checkOutput("hora_edge", rd, 32'h01);
        repeat (8) @(negedge clk);
        readReg(2'd0, rd);
        checkOutput("hora_release_data", rd, 32'h00);
        readReg(2'd2, rd);
        checkOutput("hora_release_no_capture", rd, 32'h01);
        writeReg(1'b1, 2'd2, 32'h01);
        @(negedge clk);
        checkOutput("hora_irq_cleared", {31'd0, irq}, 32'd0);
        readReg(2'd2, rd);
        checkOutput("hora_edge_cleared", rd, 32'h00);
        writeReg(1'b1, 2'd1, 32'h00);

        // btnmin bouncing with 2-cycle pulses never debounces
        $display("[TB] btnmin bounce");
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd0;
        for (int k = 0; k < 20; k++) begin
            btnmin = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            checkOutput($sformatf("min_bounce_c%0d", k), readdata & 32'h02, 32'h00);
        end
        chipselect = 1'b0;
        read       = 1'b0;
        btnmin     = 1'b1;
        repeat (8) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("min_bounce_edge", rd, 32'h00);
        readReg(2'd0, rd);
        checkOutput("min_bounce_data", rd, 32'h00);

        // swmodo on then off: both directions captured, cleared by write-1
        $display("[TB] swmodo toggle");
        swmodo = 1'b1;
        repeat (10) @(negedge clk);
        readReg(2'd0, rd);
        checkOutput("modo_data_on", rd, 32'h10);
        readReg(2'd3, rd);
        checkOutput("modo_raw_on", rd, 32'h10);
        writeReg(1'b1, 2'd2, 32'h10);
        swmodo = 1'b0;
        repeat (10) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("modo_edge_both", rd, 32'h10);
        readReg(2'd0, rd);
        checkOutput("modo_data_off", rd, 32'h00);
        writeReg(1'b1, 2'd1, 32'h10);
        readReg(2'd2, rd);
        checkOutput("modo_irq_set", {31'd0, irq}, 32'd1);
        writeReg(1'b1, 2'd2, 32'h10);
        @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("modo_edge_cleared", rd, 32'h00);
        checkOutput("modo_irq_cleared", {31'd0, irq}, 32'd0);
        writeReg(1'b1, 2'd1, 32'h00);

        // btnapagar edge coincides with a write-1-clear of bit 2: the edge wins
        $display("[TB] btnapagar edge vs clear");
        btnapagar = 1'b0;
        repeat (DEB + 1) @(negedge clk);
        writeReg(1'b1, 2'd2, 32'h04);
        readReg(2'd2, rd);
        checkOutput("apagar_edge_priority", rd, 32'h04);
        btnapagar = 1'b1;
        repeat (8) @(negedge clk);
        writeReg(1'b1, 2'd2, 32'h04);
        readReg(2'd2, rd);
        checkOutput("apagar_cleared", rd, 32'h00);

        // Reset mid-debounce with swinicio turned on across the reset
        $display("[TB] reset mid-debounce");
        writeReg(1'b1, 2'd1, 32'h1F);
        btnhora = 1'b0;
        repeat (5) @(negedge clk);
        reset    = 1'b0;
        btnhora  = 1'b1;
        swinicio = 1'b1;
        #1;
        checkOutput("midreset_readdata", readdata, 32'd0);
        checkOutput("midreset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        readReg(2'd0, rd);
        checkOutput("inicio_data_early", rd, 32'h00);
        repeat (8) @(negedge clk);
        readReg(2'd0, rd);
        checkOutput("inicio_data_settled", rd, 32'h08);
        readReg(2'd1, rd);
        checkOutput("midreset_mask", rd, 32'h00);
        readReg(2'd2, rd);
        checkOutput("midreset_no_capture", rd, 32'h00);
        readReg(2'd3, rd);
        checkOutput("inicio_raw", rd, 32'h08);
        checkOutput("midreset_irq_after", {31'd0, irq}, 32'd0);
        swinicio = 1'b0;
        repeat (10) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("inicio_fall_capture", rd, 32'h08);
        writeReg(1'b1, 2'd2, 32'h08);
        readReg(2'd2, rd);
        checkOutput("inicio_cleared", rd, 32'h00);

`ifdef ENTRADAS_AUTOREPEAT_EN
        // btnhora held 40 cycles: irq rises one cycle after each capture (press, +RDLY, +RDLY+RPER)
        $display("[TB] btnhora auto-repeat");
        writeReg(1'b1, 2'd1, 32'h01);
        prevIrq = 1'b0;
        btnhora = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chipselect = 1'b0;
            write      = 1'b0;
            writedata  = 32'd0;
            if (k == 40) btnhora = 1'b1;
            if (irq && !prevIrq) begin
                irqRises.push_back(k);
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 2'd2;
                writedata  = 32'h01;
            end
            prevIrq = irq;
        end
        chipselect = 1'b0;
        write      = 1'b0;
        checkOutput("repeat_count", (irqRises.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (irqRises.size() >= 3) begin
            checkOutput("repeat_press", irqRises[0], DEB + 3);
            checkOutput("repeat_first", irqRises[1], DEB + 3 + RDLY);
            checkOutput("repeat_second", irqRises[2], DEB + 3 + RDLY + RPER);
        end
        writeReg(1'b1, 2'd1, 32'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
